// File: rtl/ltl_report_pkg.sv
// Shared types and default sizes for the LTL report collector.
// Event layout is {reports, index}, reports in the upper bits.
package ltl_report_pkg;

    localparam int LTL_REPORT_NUM_REPORTS = 4;
    localparam int LTL_REPORT_TS_WIDTH    = 32;
    localparam int LTL_REPORT_FIFO_DEPTH  = 8;
    localparam int LTL_REPORT_DROP_WIDTH  = 16;

    typedef struct packed {
        logic [LTL_REPORT_NUM_REPORTS-1:0] reports;
        logic [LTL_REPORT_TS_WIDTH-1:0]    index;
    } report_event_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ltl_report_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ltl_report_collector.sv
// Tags non-zero automaton report vectors with their symbol index and
// buffers them for the cluster aggregator; overflow is counted, not lost.
module ltl_report_collector
    import ltl_report_pkg::*;
#(
    parameter int NUM_REPORTS = LTL_REPORT_NUM_REPORTS,
    parameter int TS_WIDTH    = LTL_REPORT_TS_WIDTH,
    parameter int FIFO_DEPTH  = LTL_REPORT_FIFO_DEPTH,
    parameter int DROP_WIDTH  = LTL_REPORT_DROP_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [NUM_REPORTS-1:0] reports,
    input  logic                   clear_overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_REPORTS-1:0] out_reports,
    output logic [TS_WIDTH-1:0]    out_index,
    output logic                   overflow,
    output logic [DROP_WIDTH-1:0]  drop_count
);

    localparam int EW = NUM_REPORTS + TS_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [TS_WIDTH-1:0]   sym_idx_q;
    logic [TS_WIDTH-1:0]   idx_q;
    logic                  run_q;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    logic          ev, push, pop, drop;
    logic          fifo_full, fifo_empty;
    logic [EW-1:0] head;
    logic [AW:0]   unused_count;

    // Reports lag their symbol by one cycle, so qualify with the delayed run.
    assign ev   = run_q && (reports != '0);
    assign pop  = out_valid && out_ready;
    assign push = ev && (!fifo_full || pop);
    assign drop = ev && !push;

    ltl_report_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({reports, idx_q}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (head),
        .count_o (unused_count)
    );

    assign out_valid   = !fifo_empty;
    assign out_reports = out_valid ? head[EW-1 -: NUM_REPORTS] : '0;
    assign out_index   = out_valid ? head[TS_WIDTH-1:0] : '0;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;

    // A drop in the clearing cycle survives the clear as the first drop.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_idx_q  <= '0;
            idx_q      <= '0;
            run_q      <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            run_q      <= run;
            idx_q      <= sym_idx_q;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            if (run) sym_idx_q <= sym_idx_q + 1'b1;
        end
    end

endmodule

// File: doc/ltl_report_collector.md
# ltl_report_collector

Downstream stage of each `Automata_ltl*` monitor: samples the automaton's report-state vector once per consumed symbol and tags each non-zero vector with the index of the symbol that caused it. It then buffers these events in a small FIFO and drains them to the monitor-cluster aggregator over a valid/ready interface. Overflow is counted and flagged, never silently lost.

## Interface
- NUM_REPORTS, 4, width of the report vector (one bit per report STE)
- TS_WIDTH, 32, symbol-index counter width
- FIFO_DEPTH, 8, event buffer entries; power of two, ≥ 2
- DROP_WIDTH, 16, dropped-event counter width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- run  in  1  symbol presented to the automaton this cycle (same signal driving STE `run`)
- reports  in  NUM_REPORTS  automaton report outputs (`*_w_out_*` of report STEs), in fixed bit order
- clear_overflow  in  1  clears `overflow` and `drop_count`
- out_valid  out  1  event available
- out_ready  in  1  consumer accepts event
- out_reports  out  NUM_REPORTS  report vector of head event
- out_index  out  TS_WIDTH  symbol index of head event
- overflow  out  1  sticky: ≥1 event dropped since reset or last clear
- drop_count  out  DROP_WIDTH  dropped events, saturating

## Operation
- `sym_idx` counts accepted symbols: +1 on every cycle with `run`=1, wraps modulo 2^TS_WIDTH; first symbol after reset has index 0.
- STE outputs are registered, so reports for the symbol at cycle t appear at cycle t+1. The block holds `run_q` <= `run` and `idx_q` <= `sym_idx` (pre-increment) each cycle.
- Event condition at cycle t+1: `run_q` && (`reports` != 0). Event entry = {reports, idx_q}. Reports while `run_q`=0 are ignored.
- Push the event if the FIFO is not full, or if it is full and a pop occurs in the same cycle (pop and push both complete; count unchanged).
- Otherwise drop the event: `drop_count` += 1 (saturating at all-ones) and `overflow` <= 1.
- `clear_overflow` zeroes `overflow` and `drop_count`. If a drop occurs in the same cycle, the result is `overflow`=1 and `drop_count`=1.
- Output is first-word-fall-through: `out_valid` = !empty; `out_reports`/`out_index` show the head entry. Pop on `out_valid && out_ready`.
- Head data stays stable while `out_valid && !out_ready`; `out_valid` never deasserts without a pop.
- `out_ready` with empty FIFO: no effect.

## Timing
- Reset values: `out_valid`=0, `out_reports`=0, `out_index`=0, `overflow`=0, `drop_count`=0, FIFO empty, `sym_idx`=0, `run_q`=0.
- Reset mid-operation discards all buffered events and zeroes all counters on the next edge.
- Latency: symbol at cycle t → reports visible at t+1 → `out_valid` at t+2 when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- No combinational path from `out_ready` to `out_valid`.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, with the MSB distinguishing full from empty. Pointers wrap naturally.

## Structure
- Package `ltl_report_pkg`:
  - `report_event_t` struct {reports, index}, parameterised through localparams matching the defaults
  - `LTL_REPORT_TS_WIDTH` constant
- Sub-module `ltl_report_fifo`: generic synchronous FWFT FIFO (DEPTH, WIDTH; push/full/pop/empty/count). The collector adds the index counter, event detection and drop/overflow logic.

## Test plan
- Reset, then `run`=1 for 3 cycles with `reports`=0,4'b0010,0 (aligned one cycle late), `out_ready`=1 → exactly one event: out_reports=4'b0010, out_index=1, out_valid high at cycle 3 for one cycle.
- `run` toggling 1,0,1 with reports held at 4'b1000 throughout → events only for indices 0 and 1; no event for the idle cycle.
- `out_ready`=0; 10 qualifying events at FIFO_DEPTH=8 → 8 buffered (indices 0..7), overflow=1, drop_count=2; then drain → indices 0..7 in order, data stable during stall.
- FIFO full, push and pop in the same cycle → event accepted, drop_count unchanged, count stays 8.
- `clear_overflow` in the same cycle as a drop → overflow=1, drop_count=1. drop_count preloaded near saturation (force DROP_WIDTH=2) with 5 drops → holds at 3.
- Reset asserted with 5 events buffered → next cycle out_valid=0, and the next event after reset has out_index=0.
